// File: rtl/toggle_pkg.sv
// Shared types and defaults for the push-button toggle request generator.
package toggle_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DB_PRESS,
    S_HELD,
    S_REPEAT,
    S_DB_RELEASE
  } tog_state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_REPEAT_DELAY    = 16;
  localparam int DEF_REPEAT_PERIOD   = 8;
  localparam int PRESS_CNT_W         = 8;

  // Largest of three timing parameters; sizes the shared state counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level, cleared by reset.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Two-stage capture; reset forces the synchronised level to 0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/toggle_req_gen.sv
// Push-button front end: synchronise, debounce, optional auto-repeat, and
// emit single-cycle toggle pulses plus a held flag and a press counter.
module toggle_req_gen
  import toggle_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   btn_async,
  input  logic                   repeat_en,
  output logic                   t_out,
  output logic                   pressed,
  output logic [PRESS_CNT_W-1:0] press_count
);

  localparam int CNT_MAX = max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic                   w_btn_s;
  tog_state_t             r_state;
  tog_state_t             w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic                   w_pulse;
  logic                   w_press;
  logic                   w_pressed_nxt;
  logic                   r_t_out;
  logic                   r_pressed;
  logic [PRESS_CNT_W-1:0] r_press_count;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (btn_async),
    .o_q   (w_btn_s)
  );

  // Next state, counter and pulse requests; release always wins over a pulse.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_pulse     = 1'b0;
    w_press     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (w_btn_s) w_state_nxt = S_DB_PRESS;
      end
      S_DB_PRESS: begin
        if (!w_btn_s) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == DB_LAST) begin
          w_state_nxt = S_HELD;
          w_pulse     = 1'b1;
          w_press     = 1'b1;
        end
      end
      S_HELD: begin
        if (!w_btn_s) begin
          w_state_nxt = S_DB_RELEASE;
        end else if (r_cnt == RD_LAST) begin
          // Parks at the delay limit so a late repeat_en fires at once.
          w_cnt_nxt = r_cnt;
          if (repeat_en) begin
            w_state_nxt = S_REPEAT;
            w_pulse     = 1'b1;
          end
        end
      end
      S_REPEAT: begin
        if (!w_btn_s) begin
          w_state_nxt = S_DB_RELEASE;
        end else if (!repeat_en) begin
          w_state_nxt = S_HELD;
        end else if (r_cnt == RP_LAST) begin
          w_pulse   = 1'b1;
          w_cnt_nxt = '0;
        end
      end
      S_DB_RELEASE: begin
        if (w_btn_s) begin
          w_state_nxt = S_HELD;
        end else if (r_cnt == DB_LAST) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_state_nxt != r_state) w_cnt_nxt = '0;
  end

  assign w_pressed_nxt = (w_state_nxt == S_HELD) || (w_state_nxt == S_REPEAT) ||
                         (w_state_nxt == S_DB_RELEASE);

  // State and shared counter register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Registered outputs; the press counter wraps naturally at its width.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_t_out       <= 1'b0;
      r_pressed     <= 1'b0;
      r_press_count <= '0;
    end else begin
      r_t_out   <= w_pulse;
      r_pressed <= w_pressed_nxt;
      if (w_press) r_press_count <= r_press_count + 1'b1;
    end
  end

  assign t_out       = r_t_out;
  assign pressed     = r_pressed;
  assign press_count = r_press_count;

endmodule

// File: tb/tb_toggle_req_gen.sv
// Bench for toggle_req_gen: segment table, hand-timed corner sequences and
// randomized button activity checked against an event-level model.
module tb_toggle_req_gen;

  localparam int DB = 4;
  localparam int RD = 16;
  localparam int RP = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_async = 1'b0;
  logic       repeat_en = 1'b0;
  logic       t_out;
  logic       pressed;
  logic [7:0] press_count;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  toggle_req_gen #(
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_async   (btn_async),
    .repeat_en   (repeat_en),
    .t_out       (t_out),
    .pressed     (pressed),
    .press_count (press_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: debounced level plus run lengths and time since the
  // hold/repeat timer last restarted, evaluated once per rising edge.
  bit ms1, ms2, bs;
  bit m_held, m_rpt, m_t;
  int m_run, m_since, m_cnt;

  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      ms1 = 0; ms2 = 0; m_held = 0; m_rpt = 0; m_t = 0;
      m_run = 0; m_since = 0; m_cnt = 0;
    end else begin
      bs  = ms2;
      ms2 = ms1;
      ms1 = btn_async;
      m_t = 0;
      if (!m_held) begin
        // A press needs DB+1 consecutive high samples starting from rest.
        m_run = bs ? m_run + 1 : 0;
        if (m_run == DB + 1) begin
          m_held = 1; m_t = 1; m_cnt = (m_cnt + 1) % 256;
          m_run = 0; m_since = 0; m_rpt = 0;
        end
      end else if (!bs) begin
        m_run++;
        if (m_run == DB + 1) begin
          m_held = 0; m_run = 0;
        end
      end else if (m_run > 0) begin
        // Release aborted: back to plain hold, delay restarts.
        m_run = 0; m_since = 0; m_rpt = 0;
      end else begin
        m_since++;
        if (!m_rpt) begin
          if (repeat_en && m_since >= RD) begin
            m_t = 1; m_rpt = 1; m_since = 0;
          end
        end else if (!repeat_en) begin
          m_rpt = 0; m_since = 0;
        end else if (m_since == RP) begin
          m_t = 1; m_since = 0;
        end
      end
    end
    #1;
    chk("model_t_out", t_out, m_t);
    chk("model_pressed", pressed, m_held);
    chk("model_press_count", press_count, m_cnt);
  end

  typedef struct {
    logic btn;
    logic ren;
    int   len;
    int   pulses;
    logic pr;
    int   pc;
  } vec_t;

  vec_t vecs[14];
  int   q_off[$];

  initial begin
    int np, w, base;
    vecs[0]  = '{1'b0, 1'b0, 10, 0, 1'b0, 0};
    vecs[1]  = '{1'b1, 1'b0, 40, 1, 1'b1, 1};   // clean press
    vecs[2]  = '{1'b0, 1'b0, 10, 0, 1'b0, 1};   // clean release
    vecs[3]  = '{1'b1, 1'b0, 1,  0, 1'b0, 1};   // bounce 1
    vecs[4]  = '{1'b0, 1'b0, 3,  0, 1'b0, 1};
    vecs[5]  = '{1'b1, 1'b0, 2,  0, 1'b0, 1};   // bounce 2
    vecs[6]  = '{1'b0, 1'b0, 3,  0, 1'b0, 1};
    vecs[7]  = '{1'b1, 1'b0, 3,  0, 1'b0, 1};   // bounce 3
    vecs[8]  = '{1'b0, 1'b0, 4,  0, 1'b0, 1};
    vecs[9]  = '{1'b1, 1'b0, 20, 1, 1'b1, 2};   // settles high
    vecs[10] = '{1'b0, 1'b0, 10, 0, 1'b0, 2};
    vecs[11] = '{1'b1, 1'b1, 64, 7, 1'b1, 3};   // press + 6 repeats
    vecs[12] = '{1'b1, 1'b0, 30, 0, 1'b1, 3};   // repeat_en dropped
    vecs[13] = '{1'b0, 1'b0, 10, 0, 1'b0, 3};

    // Reset state
    repeat (3) step();
    chk("reset_t_out", t_out, 0);
    chk("reset_pressed", pressed, 0);
    chk("reset_press_count", press_count, 0);
    reset = 1'b1;

    // Segment table
    foreach (vecs[i]) begin
      btn_async = vecs[i].btn;
      repeat_en = vecs[i].ren;
      np = 0;
      for (int c = 0; c < vecs[i].len; c++) begin
        step();
        if (t_out) np++;
      end
      chk($sformatf("vec%0d_pulses", i), np, vecs[i].pulses);
      chk($sformatf("vec%0d_pressed", i), pressed, vecs[i].pr);
      chk($sformatf("vec%0d_press_count", i), press_count, vecs[i].pc);
    end

    // Press latency: pulse exactly DB+2 edges after the first high edge
    btn_async = 1'b1;
    repeat (6) step();
    chk("lat_pre_t_out", t_out, 0);
    chk("lat_pre_pressed", pressed, 0);
    step();
    chk("lat_t_out", t_out, 1);
    chk("lat_pressed", pressed, 1);
    step();
    chk("lat_post_t_out", t_out, 0);
    repeat (5) step();

    // Release latency: pressed falls DB+2 edges after btn falls
    btn_async = 1'b0;
    repeat (6) step();
    chk("rel_pre_pressed", pressed, 1);
    step();
    chk("rel_pressed", pressed, 0);
    repeat (4) step();

    // Auto-repeat spacing relative to the press pulse
    repeat_en = 1'b1;
    btn_async = 1'b1;
    w = 0;
    do begin
      step();
      w++;
    end while (!t_out && w < 20);
    chk("rep_press_seen", t_out, 1);
    base = cyc;
    for (int c = 0; c < 60; c++) begin
      step();
      if (t_out) q_off.push_back(cyc - base);
    end
    chk("rep_num_pulses", q_off.size(), 6);
    foreach (q_off[i]) chk($sformatf("rep_off%0d", i), q_off[i], RD + RP * i);

    // repeat_en drop while held: silence, still pressed
    repeat_en = 1'b0;
    np = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (t_out) np++;
    end
    chk("drop_pulses", np, 0);
    chk("drop_pressed", pressed, 1);

    // Mid-repeat reset, then a full debounce from rest
    repeat_en = 1'b1;
    repeat (20) step();
    reset = 1'b0;
    step();
    chk("midrst_t_out", t_out, 0);
    chk("midrst_pressed", pressed, 0);
    chk("midrst_press_count", press_count, 0);
    reset = 1'b1;
    np = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (t_out) np++;
    end
    chk("midrst_early_pulses", np, 0);
    chk("midrst_early_pressed", pressed, 0);
    step();
    chk("midrst_repress_t_out", t_out, 1);
    chk("midrst_repress_count", press_count, 1);

    // Counter wrap over 257 presses
    btn_async = 1'b0;
    repeat_en = 1'b0;
    reset = 1'b0;
    step();
    reset = 1'b1;
    for (int i = 1; i <= 257; i++) begin
      btn_async = 1'b1;
      repeat (8) step();
      btn_async = 1'b0;
      repeat (8) step();
      if (i == 255) chk("wrap_255", press_count, 255);
      if (i == 256) chk("wrap_256", press_count, 0);
      if (i == 257) chk("wrap_257", press_count, 1);
    end

    // Randomized runs with occasional resets, checked by the model
    for (int i = 0; i < 4000; ) begin
      int len;
      len = $urandom_range(1, 30);
      btn_async = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) repeat_en = ~repeat_en;
      for (int c = 0; c < len; c++) begin
        reset = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
        step();
        i++;
      end
    end
    reset = 1'b1;
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
